fifo_sc_fwft: RTL

//  Single-clock register FIFO for SpaceWire TX/RX data paths (9-bit char = 8 data + control flag).

---
 rtl/fifo_sc_fwft.sv | 93 +++++++++
 1 files changed

// File: rtl/fifo_sc_fwft.sv
// Single-clock register FIFO with occupancy count, optional first-word-fall-through output,
// programmable almost-full/almost-empty thresholds, overflow/underflow pulses and synchronous flush.
module fifo_sc_fwft #(
  parameter int DATA_SIZE    = 9,
  parameter int ADDR_SIZE    = 7,
  parameter int FWFT         = 0,
  parameter int AFULL_LEVEL  = 120,
  parameter int AEMPTY_LEVEL = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [DATA_SIZE-1:0] data,
  input  logic                 wrreq,
  input  logic                 rdreq,
  output logic [DATA_SIZE-1:0] q,
  output logic                 rdempty,
  output logic                 wrfull,
  output logic [ADDR_SIZE:0]   usedw,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int                 DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AF_L  = (ADDR_SIZE+1)'(AFULL_LEVEL);
  localparam logic [ADDR_SIZE:0] AE_L  = (ADDR_SIZE+1)'(AEMPTY_LEVEL);

  logic [ADDR_SIZE:0]   r_waddr, r_raddr;
  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic                 r_ovf, r_udf;

  logic                 w_empty, w_full, w_wr_ok, w_rd_ok;
  logic [ADDR_SIZE:0]   w_used;
  logic [ADDR_SIZE-1:0] w_wa, w_ra;

  // Extra pointer MSB distinguishes full from empty when the low bits coincide.
  assign w_wa    = r_waddr[ADDR_SIZE-1:0];
  assign w_ra    = r_raddr[ADDR_SIZE-1:0];
  assign w_empty = (r_waddr == r_raddr);
  assign w_full  = (w_wa == w_ra) && (r_waddr[ADDR_SIZE] != r_raddr[ADDR_SIZE]);
  assign w_used  = r_waddr - r_raddr;
  assign w_wr_ok = wrreq && !w_full;
  assign w_rd_ok = rdreq && !w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (clr) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_ok) r_waddr <= r_waddr + 1'b1;
      if (w_rd_ok) r_raddr <= r_raddr + 1'b1;
      r_ovf <= wrreq && w_full;
      r_udf <= rdreq && w_empty;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !clr) r_mem[w_wa] <= data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign q = w_empty ? '0 : r_mem[w_ra];
    end else begin : g_std
      logic [DATA_SIZE-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_q <= '0;
        else if (clr)     r_q <= '0;
        else if (w_rd_ok) r_q <= r_mem[w_ra];
      end
      assign q = r_q;
    end
  endgenerate

  assign rdempty      = w_empty;
  assign wrfull       = w_full;
  assign usedw        = w_used;
  assign almost_full  = (w_used >= AF_L);
  assign almost_empty = (w_used <= AE_L);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule
